cmd_frame_dispatcher: RTL and testbench

// - Parses the UART byte stream into key-value ledger commands: opcode byte, then big-endian key, then kind/value fields.
// - Supports create, issue, transfer and refer. Replaces the per-command byte gating in front of the hash/BRAM engine.
// - Presents one complete command record per frame on a valid/ready handshake.
// - Widths are parametrised. Bad frames and overruns are reported.

---
 rtl/cmd_pkg.sv | 28 ++
 rtl/cmd_field_shreg.sv | 19 +
 rtl/cmd_frame_dispatcher.sv | 133 +++++++++++++
 tb/tb_cmd_frame_dispatcher.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// cmd_pkg: shared opcodes, record signal encodings, error codes and FSM states for the command dispatcher
package cmd_pkg;
    localparam logic [7:0] OP_ISSUE    = 8'd1;
    localparam logic [7:0] OP_TRANSFER = 8'd2;
    localparam logic [7:0] OP_REFER    = 8'd3;
    localparam logic [7:0] OP_CREATE   = 8'd4;
    localparam logic [1:0] SIG_REFER    = 2'b00;
    localparam logic [1:0] SIG_CREATE   = 2'b01;
    localparam logic [1:0] SIG_ISSUE    = 2'b10;
    localparam logic [1:0] SIG_TRANSFER = 2'b11;
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OPCODE   = 2'b01;
    localparam logic [1:0] ERR_OVERRUN  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_KEY  = 3'd1;
    localparam state_t ST_KIND = 3'd2;
    localparam state_t ST_VAL  = 3'd3;
    localparam state_t ST_OUT  = 3'd4;
    function automatic logic op_ok(input logic [7:0] op);
        return op >= OP_ISSUE && op <= OP_CREATE;
    endfunction
    function automatic logic [1:0] op_sig(input logic [7:0] op);
        return op == OP_ISSUE ? SIG_ISSUE : op == OP_TRANSFER ? SIG_TRANSFER :
               op == OP_CREATE ? SIG_CREATE : SIG_REFER;
    endfunction
endpackage

// File: rtl/cmd_field_shreg.sv
// cmd_field_shreg: byte-wide load-shift register with synchronous clear, MSB-first accumulation
// Ports: clk, reset (async active-low), clr (zero the field), shift (append din as new LSB byte),
//        din[7:0] incoming byte, q[W-1:0] accumulated field
module cmd_field_shreg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         shift,
    input  logic [7:0]   din,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else if (clr) q <= '0;
        else if (shift) q <= (q << 8) | W'(din);
    end
endmodule

// File: rtl/cmd_frame_dispatcher.sv
// cmd_frame_dispatcher: parses a UART byte stream into ledger command records on a valid/ready handshake
// Ports: clk, reset (async active-low), tick_in (baud tick, timeout only), rx_byte/rx_valid (byte strobe),
//        cmd_valid/cmd_ready handshake, cmd_signal/cmd_key/cmd_value/cmd_transact_kind/cmd_transact_value
//        record fields, busy (frame or record pending), err_valid/err_code (1-cycle error pulse, held code)
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module cmd_frame_dispatcher
    import cmd_pkg::*;
#(
    parameter int KEY_W         = 32,
    parameter int VAL_W         = 32,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_signal,
    output logic [KEY_W-1:0] cmd_key,
    output logic [VAL_W-1:0] cmd_value,
    output logic             cmd_transact_kind,
    output logic [VAL_W-1:0] cmd_transact_value,
    output logic             busy,
    output logic             err_valid,
    output logic [1:0]       err_code
);
    localparam int KB = KEY_W / 8;
    localparam int VB = VAL_W / 8;
    localparam int CW = $clog2((KEY_W > VAL_W ? KEY_W : VAL_W) / 8) + 1;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          start, key_end, val_end, timeout;
    assign start   = state == ST_IDLE && rx_valid && op_ok(rx_byte);
    assign key_end = cnt == CW'(KB - 1);
    assign val_end = cnt == CW'(VB - 1);
    assign cmd_valid = state == ST_OUT;
    assign busy      = state != ST_IDLE;
`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] ticks;
    logic          in_frame;
    assign in_frame = state == ST_KEY || state == ST_KIND || state == ST_VAL;
    // A byte arriving on the expiry tick keeps the frame alive.
    assign timeout  = in_frame && tick_in && !rx_valid && ticks == TW'(TIMEOUT_TICKS - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ticks <= '0;
        else if (rx_valid || !in_frame) ticks <= '0;
        else if (tick_in) ticks <= ticks + 1'b1;
    end
`else
    logic unused_tick;
    assign unused_tick = tick_in & (TIMEOUT_TICKS > 0);
    assign timeout     = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            cmd_signal        <= SIG_REFER;
            cmd_transact_kind <= 1'b0;
            err_valid         <= 1'b0;
            err_code          <= ERR_NONE;
        end else begin
            err_valid <= 1'b0;
            if (timeout) begin
                state     <= ST_IDLE;
                err_valid <= 1'b1;
                err_code  <= ERR_TIMEOUT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state             <= ST_KEY;
                            cnt               <= '0;
                            cmd_signal        <= op_sig(rx_byte);
                            cmd_transact_kind <= 1'b0;
                        end else if (rx_valid && rx_byte != 8'h00) begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_OPCODE;
                        end
                    end
                    ST_KEY: begin
                        if (rx_valid) begin
                            cnt <= key_end ? '0 : cnt + 1'b1;
                            if (key_end)
                                state <= cmd_signal == SIG_REFER ? ST_OUT :
                                         cmd_signal == SIG_CREATE ? ST_VAL : ST_KIND;
                        end
                    end
                    ST_KIND: begin
                        if (rx_valid) begin
                            cmd_transact_kind <= rx_byte[0];
                            state             <= ST_VAL;
                            cnt               <= '0;
                        end
                    end
                    ST_VAL: begin
                        if (rx_valid) begin
                            cnt <= val_end ? '0 : cnt + 1'b1;
                            if (val_end) state <= ST_OUT;
                        end
                    end
                    ST_OUT: begin
                        if (cmd_ready) state <= ST_IDLE;
                        // Overrun byte is dropped; the held record is untouched.
                        if (rx_valid) begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_OVERRUN;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
    cmd_field_shreg #(.W(KEY_W)) u_key (
        .clk(clk), .reset(reset), .clr(start),
        .shift(state == ST_KEY && rx_valid && !timeout),
        .din(rx_byte), .q(cmd_key)
    );
    cmd_field_shreg #(.W(VAL_W)) u_value (
        .clk(clk), .reset(reset), .clr(start),
        .shift(state == ST_VAL && rx_valid && cmd_signal == SIG_CREATE),
        .din(rx_byte), .q(cmd_value)
    );
    cmd_field_shreg #(.W(VAL_W)) u_tv (
        .clk(clk), .reset(reset), .clr(start),
        .shift(state == ST_VAL && rx_valid && cmd_signal != SIG_CREATE),
        .din(rx_byte), .q(cmd_transact_value)
    );
endmodule

// File: tb/tb_cmd_frame_dispatcher.sv
// tb_cmd_frame_dispatcher: directed and randomized frames checked against a field-level record model
module tb_cmd_frame_dispatcher;
    import cmd_pkg::*;
    localparam int KW = 32;
    localparam int VW = 32;
    localparam int TT = 4;
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick_in = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_valid = 1'b0;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid, cmd_transact_kind, busy, err_valid;
    logic [1:0]    cmd_signal, err_code;
    logic [KW-1:0] cmd_key;
    logic [VW-1:0] cmd_value, cmd_transact_value;
    int total = 0, passed = 0, accepts = 0, errs = 0;

    cmd_frame_dispatcher #(.KEY_W(KW), .VAL_W(VW), .TIMEOUT_TICKS(TT)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_signal(cmd_signal), .cmd_key(cmd_key),
        .cmd_value(cmd_value), .cmd_transact_kind(cmd_transact_kind),
        .cmd_transact_value(cmd_transact_value), .busy(busy), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) accepts++;
        if (err_valid) errs++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] k, input logic [31:0] v,
                              input logic [7:0] kb, input logic [31:0] t);
        send(op);
        for (int i = KW/8 - 1; i >= 0; i--) send(k[8*i +: 8]);
        if (op == 8'd4)
            for (int i = VW/8 - 1; i >= 0; i--) send(v[8*i +: 8]);
        if (op == 8'd1 || op == 8'd2) begin
            send(kb);
            for (int i = VW/8 - 1; i >= 0; i--) send(t[8*i +: 8]);
        end
    endtask

    task automatic check_rec(input string tag, input logic [7:0] op, input logic [31:0] k,
                             input logic [31:0] v, input logic [7:0] kb, input logic [31:0] t);
        logic [1:0] es;
        logic       xfer;
        es   = op == 8'd1 ? 2'b10 : op == 8'd2 ? 2'b11 : op == 8'd4 ? 2'b01 : 2'b00;
        xfer = op == 8'd1 || op == 8'd2;
        chk({tag, ".valid"}, cmd_valid, 1);
        chk({tag, ".signal"}, cmd_signal, es);
        chk({tag, ".key"}, cmd_key, k);
        chk({tag, ".value"}, cmd_value, op == 8'd4 ? v : 32'h0);
        chk({tag, ".kind"}, cmd_transact_kind, xfer ? kb[0] : 1'b0);
        chk({tag, ".tv"}, cmd_transact_value, xfer ? t : 32'h0);
    endtask

    task automatic accept(input string tag);
        int a0;
        a0 = accepts;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk({tag, ".acc_once"}, accepts, a0 + 1);
        chk({tag, ".valid_drop"}, cmd_valid, 0);
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        int a0, e0;
        logic [7:0]  op, kb;
        logic [31:0] k, v, t;
        repeat (3) @(negedge clk);
        chk("rst.valid", cmd_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.err_valid", err_valid, 0);
        chk("rst.err_code", err_code, 0);
        chk("rst.signal", cmd_signal, 0);
        chk("rst.key", cmd_key, 0);
        chk("rst.value", cmd_value, 0);
        chk("rst.kind", cmd_transact_kind, 0);
        chk("rst.tv", cmd_transact_value, 0);
        reset = 1'b1;

        cmd_ready = 1'b1;
        send_frame(8'h03, 32'hDEADBEEF, 0, 0, 0);
        check_rec("refer", 8'h03, 32'hDEADBEEF, 0, 0, 0);
        a0 = accepts;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("refer.pulse", cmd_valid, 0);
        chk("refer.acc", accepts, a0 + 1);

        send_frame(8'h01, 32'h7, 0, 8'h01, 32'h1F4);
        for (int i = 0; i < 5; i++) begin
            check_rec("issue_bp", 8'h01, 32'h7, 0, 8'h01, 32'h1F4);
            @(negedge clk);
        end
        accept("issue_bp");

        e0 = errs;
        cmd_ready = 1'b1;
        send_frame(8'h04, 32'h2A, 32'h64, 0, 0);
        check_rec("create", 8'h04, 32'h2A, 32'h64, 0, 0);
        send_frame(8'h03, 32'h2A, 0, 0, 0);
        check_rec("b2b_refer", 8'h03, 32'h2A, 0, 0, 0);
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("b2b.no_err", errs, e0);

        send(8'h00);
        chk("filler.err", err_valid, 0);
        chk("filler.busy", busy, 0);
        send(8'h09);
        chk("badop.err", err_valid, 1);
        chk("badop.code", err_code, 1);
        chk("badop.busy", busy, 0);
        send_frame(8'h03, 32'h1, 0, 0, 0);
        check_rec("after_bad", 8'h03, 32'h1, 0, 0, 0);
        chk("badop.code_held", err_code, 1);
        accept("after_bad");

        k = $urandom; kb = 8'($urandom); t = $urandom;
        send_frame(8'h02, k, 0, kb, t);
        check_rec("xfer", 8'h02, k, 0, kb, t);
        send(8'h55);
        chk("overrun.err", err_valid, 1);
        chk("overrun.code", err_code, 2);
        check_rec("overrun.rec", 8'h02, k, 0, kb, t);
        @(negedge clk);
        rx_byte = 8'h66; rx_valid = 1'b1; cmd_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; cmd_ready = 1'b0;
        chk("overrun_acc.err", err_valid, 1);
        chk("overrun_acc.code", err_code, 2);
        chk("overrun_acc.valid", cmd_valid, 0);
        chk("overrun_acc.busy", busy, 0);

        send(8'h03);
        send(8'hDE);
        chk("midrst.busy_before", busy, 1);
        a0 = accepts; e0 = errs;
        reset = 1'b0;
        #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.valid", cmd_valid, 0);
        chk("midrst.err", err_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        cmd_ready = 1'b0;
        chk("midrst.no_rec", accepts, a0);
        chk("midrst.no_err", errs, e0);
        chk("midrst.idle", busy, 0);

`ifdef CMD_TIMEOUT_EN
        send(8'h02);
        send(8'h00);
        repeat (TT - 1) tick();
        chk("to.not_yet", err_valid, 0);
        chk("to.busy_yet", busy, 1);
        tick();
        chk("to.err", err_valid, 1);
        chk("to.code", err_code, 3);
        chk("to.busy", busy, 0);
        send_frame(8'h01, 32'h12345678, 0, 8'h00, 32'h9);
        check_rec("to.next", 8'h01, 32'h12345678, 0, 8'h00, 32'h9);
        accept("to.next");
`else
        e0 = errs;
        send(8'h03);
        repeat (20) tick();
        chk("notick.busy", busy, 1);
        for (int i = 3; i >= 0; i--) send(8'hA0 + 8'(i));
        check_rec("notick", 8'h03, 32'hA3A2A1A0, 0, 0, 0);
        accept("notick");
        chk("notick.no_err", errs, e0);
`endif

        e0 = errs;
        for (int n = 0; n < 24; n++) begin
            op = 8'($urandom_range(1, 4));
            k = $urandom; v = $urandom; kb = 8'($urandom); t = $urandom;
            if ($urandom_range(0, 1) == 1) send(8'h00);
            send_frame(op, k, v, kb, t);
            check_rec("rand", op, k, v, kb, t);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept("rand");
        end
        chk("rand.no_err", errs, e0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
